// File: rtl/ahb_sram_ctrl.sv
// AHB-Lite slave for a 3K x 32 synchronous SRAM: zero wait states, one-entry write buffer, read forwarding.
// Optional build macro AHB_SRAM_RANGE_ERR_EN turns word indices >= DEPTH into a two-cycle ERROR response.
module ahb_sram_ctrl #(
  parameter int AW    = 12,
  parameter int DEPTH = 3072
) (
  input  logic          HCLK,
  input  logic          HRESETn,
  input  logic          HSEL,
  input  logic [31:0]   HADDR,
  input  logic [1:0]    HTRANS,
  input  logic          HWRITE,
  input  logic [2:0]    HSIZE,
  input  logic [31:0]   HWDATA,
  input  logic          HREADY,
  output logic          HREADYOUT,
  output logic [31:0]   HRDATA,
  output logic          HRESP,
  input  logic [31:0]   SRAMRDATA,
  output logic [3:0]    SRAMWEN,
  output logic [31:0]   SRAMWDATA,
  output logic          SRAMCS0,
  output logic [AW-1:0] SRAMADDR
);

  typedef enum logic [1:0] {ST_IDLE = 2'd0, ST_ERR1 = 2'd1, ST_ERR2 = 2'd2} state_e;

  localparam logic [AW:0] DEPTH_W = (AW+1)'(DEPTH);

  function automatic logic [3:0] lane_be(input logic [2:0] size, input logic [1:0] lo);
    case (size)
      3'd0:    lane_be = 4'b0001 << lo;
      3'd1:    lane_be = lo[1] ? 4'b1100 : 4'b0011;
      3'd2:    lane_be = 4'b1111;
      default: lane_be = 4'b0000;
    endcase
  endfunction

  logic [AW-1:0] idx_s;
  logic [3:0]    be_s;
  logic          acc_s, size_err_s, in_range_s, err_s, rd_acc_s, wr_acc_s;
  logic          unused_s;

  state_e        state_q, state_d;
  logic          hreadyout_q, hreadyout_d, hresp_q, hresp_d;
  logic          dp_wr_q, dp_wr_d, dp_rd_q, dp_rd_d;
  logic [AW-1:0] dp_addr_q, dp_addr_d;
  logic [3:0]    dp_be_q, dp_be_d;
  logic          buf_v_q, buf_v_d;
  logic [AW-1:0] buf_addr_q, buf_addr_d;
  logic [3:0]    buf_be_q, buf_be_d;
  logic [31:0]   buf_data_q, buf_data_d;

  logic          sram_cs_s;
  logic [3:0]    sram_wen_s;
  logic [AW-1:0] sram_addr_s;
  logic [31:0]   sram_wdata_s;
  logic [31:0]   rdata_s;

  assign unused_s = ^{HADDR[31:AW+2], HTRANS[0]};

  // Address-phase decode
  always_comb begin
    idx_s      = HADDR[AW+1:2];
    be_s       = lane_be(HSIZE, HADDR[1:0]);
    acc_s      = HSEL & HREADY & HTRANS[1];
    size_err_s = (HSIZE > 3'd2);
    in_range_s = ({1'b0, idx_s} < DEPTH_W);
`ifdef AHB_SRAM_RANGE_ERR_EN
    err_s      = size_err_s | ~in_range_s;
`else
    err_s      = size_err_s;
`endif
    // Out-of-range transfers never touch the macro in either build.
    rd_acc_s   = acc_s & ~HWRITE & ~err_s & in_range_s;
    wr_acc_s   = acc_s &  HWRITE & ~err_s & in_range_s;
  end

  // Next state: error sequencing, data-phase capture, macro port arbitration and write buffer
  always_comb begin
    state_d      = state_q;
    hreadyout_d  = 1'b1;
    hresp_d      = 1'b0;
    dp_wr_d      = wr_acc_s;
    dp_rd_d      = rd_acc_s;
    dp_addr_d    = idx_s;
    dp_be_d      = be_s;
    buf_v_d      = buf_v_q;
    buf_addr_d   = buf_addr_q;
    buf_be_d     = buf_be_q;
    buf_data_d   = buf_data_q;
    sram_cs_s    = 1'b0;
    sram_wen_s   = 4'b0000;
    sram_addr_s  = idx_s;
    sram_wdata_s = buf_data_q;

    case (state_q)
      ST_ERR1: begin
        state_d     = ST_ERR2;
        hreadyout_d = 1'b1;
        hresp_d     = 1'b1;
      end
      ST_IDLE, ST_ERR2: begin
        if (acc_s & err_s) begin
          state_d     = ST_ERR1;
          hreadyout_d = 1'b0;
          hresp_d     = 1'b1;
        end else begin
          state_d     = ST_IDLE;
          hreadyout_d = 1'b1;
          hresp_d     = 1'b0;
        end
      end
      default: begin
        state_d     = ST_IDLE;
        hreadyout_d = 1'b1;
        hresp_d     = 1'b0;
      end
    endcase

    // A read owns the port; a data-phase write colliding with it is parked in the buffer.
    if (rd_acc_s) begin
      sram_cs_s   = 1'b1;
      sram_addr_s = idx_s;
      if (dp_wr_q) begin
        buf_v_d    = 1'b1;
        buf_addr_d = dp_addr_q;
        buf_be_d   = dp_be_q;
        buf_data_d = HWDATA;
      end else begin
        buf_v_d    = buf_v_q;
      end
    end else if (buf_v_q) begin
      sram_cs_s    = 1'b1;
      sram_wen_s   = buf_be_q;
      sram_addr_s  = buf_addr_q;
      sram_wdata_s = buf_data_q;
      buf_v_d      = 1'b0;
    end else if (dp_wr_q) begin
      sram_cs_s    = 1'b1;
      sram_wen_s   = dp_be_q;
      sram_addr_s  = dp_addr_q;
      sram_wdata_s = HWDATA;
    end else begin
      sram_cs_s    = 1'b0;
    end
  end

  // Read data merge: bytes held in the write buffer override stale macro data
  always_comb begin
    rdata_s = 32'd0;
    if (dp_rd_q) begin
      for (int i = 0; i < 4; i++) begin
        if (buf_v_q && (buf_addr_q == dp_addr_q) && buf_be_q[i]) begin
          rdata_s[8*i +: 8] = buf_data_q[8*i +: 8];
        end else begin
          rdata_s[8*i +: 8] = SRAMRDATA[8*i +: 8];
        end
      end
    end else begin
      rdata_s = 32'd0;
    end
  end

  // State and output registers
  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      state_q     <= ST_IDLE;
      hreadyout_q <= 1'b1;
      hresp_q     <= 1'b0;
      dp_wr_q     <= 1'b0;
      dp_rd_q     <= 1'b0;
      dp_addr_q   <= '0;
      dp_be_q     <= 4'b0000;
      buf_v_q     <= 1'b0;
      buf_addr_q  <= '0;
      buf_be_q    <= 4'b0000;
      buf_data_q  <= 32'd0;
    end else begin
      state_q     <= state_d;
      hreadyout_q <= hreadyout_d;
      hresp_q     <= hresp_d;
      dp_wr_q     <= dp_wr_d;
      dp_rd_q     <= dp_rd_d;
      dp_addr_q   <= dp_addr_d;
      dp_be_q     <= dp_be_d;
      buf_v_q     <= buf_v_d;
      buf_addr_q  <= buf_addr_d;
      buf_be_q    <= buf_be_d;
      buf_data_q  <= buf_data_d;
    end
  end

  // The macro must stay idle while reset is held, even if the bus presents a read.
  assign SRAMCS0   = sram_cs_s & HRESETn;
  assign SRAMWEN   = sram_wen_s & {4{HRESETn}};
  assign SRAMADDR  = sram_addr_s;
  assign SRAMWDATA = sram_wdata_s;
  assign HREADYOUT = hreadyout_q;
  assign HRESP     = hresp_q;
  assign HRDATA    = rdata_s;

endmodule

// File: tb/tb_ahb_sram_ctrl.sv
// Directed bench for ahb_sram_ctrl: SRAM macro model, AHB-level memory model, per-cycle output compare.
module tb_ahb_sram_ctrl;

  localparam logic [1:0]  NS      = 2'b10;
  localparam logic [1:0]  IDL     = 2'b00;
  localparam logic [11:0] DEPTH_L = 12'd3072;

  logic        hclk;
  logic        hresetn;
  logic        hsel, hwrite;
  logic [31:0] haddr, hwdata, hrdata, sram_wdata;
  logic [31:0] sram_rdata = 32'd0;
  logic [1:0]  htrans;
  logic [2:0]  hsize;
  logic        hready, hreadyout, hresp, sram_cs;
  logic [3:0]  sram_wen;
  logic [11:0] sram_addr;

  assign hready = hreadyout;

  ahb_sram_ctrl #(.AW(12), .DEPTH(3072)) dut (
    .HCLK(hclk), .HRESETn(hresetn), .HSEL(hsel), .HADDR(haddr), .HTRANS(htrans),
    .HWRITE(hwrite), .HSIZE(hsize), .HWDATA(hwdata), .HREADY(hready),
    .HREADYOUT(hreadyout), .HRDATA(hrdata), .HRESP(hresp), .SRAMRDATA(sram_rdata),
    .SRAMWEN(sram_wen), .SRAMWDATA(sram_wdata), .SRAMCS0(sram_cs), .SRAMADDR(sram_addr)
  );

  initial hclk = 1'b0;
  always #5 hclk = ~hclk;

  int total = 0;
  int bad   = 0;
  bit chk_on = 1'b0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  // SRAM macro model: one-cycle read latency, per-byte write enables
  logic [31:0] sram_mem [0:4095];
  int          wr_count = 0;
  always @(posedge hclk) begin
    if (sram_cs) begin
      if (sram_wen == 4'b0000) begin
        sram_rdata <= sram_mem[sram_addr];
      end else begin
        for (int b = 0; b < 4; b++)
          if (sram_wen[b]) sram_mem[sram_addr][8*b +: 8] <= sram_wdata[8*b +: 8];
        wr_count <= wr_count + 1;
      end
    end
  end

  // Bus-level reference: memory image in AHB transfer order plus expected outputs
  logic [31:0] ref_mem [0:3071];
  int          m_err = 0;
  logic        m_rd_valid = 1'b0;
  logic [31:0] m_rd_data = 32'd0;
  logic        m_dp_wr = 1'b0, m_pend_valid = 1'b0;
  logic [11:0] m_dp_idx = 12'd0, m_pend_idx = 12'd0;
  logic [31:0] m_dp_old = 32'd0, m_pend_old = 32'd0;
  logic [31:0] next_hwdata = 32'h5A5A5A5A;
  logic        e_ready = 1'b1, e_resp = 1'b0;
  logic [31:0] e_rdata = 32'd0;

  always @(negedge hclk) begin
    if (chk_on) begin
      chk("hreadyout", 32'(hreadyout), 32'(e_ready));
      chk("hresp", 32'(hresp), 32'(e_resp));
      chk("hrdata", hrdata, e_rdata);
      if (sram_cs) chk("macro_range", 32'(sram_addr < DEPTH_L), 32'd1);
    end
  end

  task automatic step(input logic sel, input logic [1:0] trans, input logic wr,
                      input logic [2:0] size, input logic [31:0] addr, input logic [31:0] wd);
    logic acc, bad_x, rdport;
    logic [11:0] idx;
    logic [3:0] be;
    @(posedge hclk); #1;
    hsel = sel; htrans = trans; hwrite = wr; hsize = size; haddr = addr; hwdata = next_hwdata;
    e_ready = (m_err == 1) ? 1'b0 : 1'b1;
    e_resp  = (m_err != 0);
    e_rdata = m_rd_valid ? m_rd_data : 32'd0;
    idx    = addr[13:2];
    acc    = sel && trans[1] && (m_err != 1);
    bad_x  = (size > 3'd2);
`ifdef AHB_SRAM_RANGE_ERR_EN
    if (idx >= DEPTH_L) bad_x = 1'b1;
`endif
    rdport = acc && !bad_x && !wr && (idx < DEPTH_L);
    // A write whose data phase meets a read stays pending until the first cycle without a read.
    if (rdport && m_dp_wr) begin
      m_pend_valid = 1'b1; m_pend_idx = m_dp_idx; m_pend_old = m_dp_old;
    end else if (!rdport) begin
      m_pend_valid = 1'b0;
    end
    if (acc && bad_x) m_err = 1;
    else if (m_err == 1) m_err = 2;
    else m_err = 0;
    m_rd_valid  = acc && !bad_x && !wr;
    m_rd_data   = (idx < DEPTH_L) ? ref_mem[idx] : 32'd0;
    m_dp_wr     = 1'b0;
    next_hwdata = 32'h5A5A5A5A;
    if (acc && !bad_x && wr && (idx < DEPTH_L)) begin
      be = (size == 3'd0) ? (4'b0001 << addr[1:0]) : (size == 3'd1) ? (addr[1] ? 4'b1100 : 4'b0011) : 4'b1111;
      m_dp_wr = 1'b1; m_dp_idx = idx; m_dp_old = ref_mem[idx];
      for (int b = 0; b < 4; b++) if (be[b]) ref_mem[idx][8*b +: 8] = wd[8*b +: 8];
      next_hwdata = wd;
    end
    #3;
  endtask

  task automatic idle();
    step(1'b0, IDL, 1'b0, 3'd2, 32'd0, 32'd0);
  endtask

  task automatic reset_cycles(input int n);
    @(posedge hclk); #1;
    hresetn = 1'b0;
    hsel = 1'b1; htrans = NS; hwrite = 1'b0; hsize = 3'd2; haddr = 32'h240; hwdata = 32'h5A5A5A5A;
    if (m_dp_wr) ref_mem[m_dp_idx] = m_dp_old;
    if (m_pend_valid) ref_mem[m_pend_idx] = m_pend_old;
    m_dp_wr = 1'b0; m_pend_valid = 1'b0; m_rd_valid = 1'b0; m_err = 0;
    next_hwdata = 32'h5A5A5A5A;
    e_ready = 1'b1; e_resp = 1'b0; e_rdata = 32'd0;
    #3;
    chk("rst_cs", 32'(sram_cs), 32'd0);
    chk("rst_wen", 32'(sram_wen), 32'd0);
    chk("rst_ready", 32'(hreadyout), 32'd1);
    chk("rst_resp", 32'(hresp), 32'd0);
    chk("rst_rdata", hrdata, 32'd0);
    repeat (n) @(posedge hclk);
    #1;
    hresetn = 1'b1; hsel = 1'b0; htrans = IDL;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1);
  end

  initial begin
    int wc0;
    hresetn = 1'b1; hsel = 1'b0; htrans = IDL; hwrite = 1'b0; hsize = 3'd2;
    haddr = 32'd0; hwdata = 32'd0;
    for (int i = 0; i < 4096; i++) sram_mem[i] <= (32'(i) * 32'h01000193) ^ 32'hA5A5A5A5;
    for (int i = 0; i < 3072; i++) ref_mem[i] = (32'(i) * 32'h01000193) ^ 32'hA5A5A5A5;
    sram_mem[12'h080] <= 32'h11223344; ref_mem[12'h080] = 32'h11223344;
    sram_mem[12'h090] <= 32'h55667788; ref_mem[12'h090] = 32'h55667788;
    #1 hresetn = 1'b0;
    #1 chk_on = 1'b1;
    chk("por_ready", 32'(hreadyout), 32'd1);
    chk("por_resp", 32'(hresp), 32'd0);
    chk("por_rdata", hrdata, 32'd0);
    chk("por_cs", 32'(sram_cs), 32'd0);
    repeat (2) @(posedge hclk);
    #1 hresetn = 1'b1;

    // Word write, idle, read back
    step(1'b1, NS, 1'b1, 3'd2, 32'h100, 32'hDEADBEEF);
    idle();
    chk("t1_cs", 32'(sram_cs), 32'd1);
    chk("t1_wen", 32'(sram_wen), 32'hF);
    chk("t1_addr", 32'(sram_addr), 32'h040);
    chk("t1_wdata", sram_wdata, 32'hDEADBEEF);
    step(1'b1, NS, 1'b0, 3'd2, 32'h100, 32'd0);
    chk("t1_rd_wen", 32'(sram_wen), 32'd0);
    idle();
    chk("t1_rdata", hrdata, 32'hDEADBEEF);

    // Byte write then immediate word read of the same word: forwarding and deferred commit
    step(1'b1, NS, 1'b1, 3'd0, 32'h203, 32'hAA000000);
    step(1'b1, NS, 1'b0, 3'd2, 32'h200, 32'd0);
    chk("t2_rd_first_cs", 32'(sram_cs), 32'd1);
    chk("t2_rd_first_wen", 32'(sram_wen), 32'd0);
    chk("t2_rd_first_addr", 32'(sram_addr), 32'h080);
    idle();
    chk("t2_fwd", hrdata, 32'hAA223344);
    chk("t2_commit_wen", 32'(sram_wen), 32'h8);
    chk("t2_commit_addr", 32'(sram_addr), 32'h080);

    // Write followed by three back-to-back reads: buffer held, single commit
    step(1'b1, NS, 1'b1, 3'd2, 32'h10, 32'h0BADF00D);
    wc0 = wr_count;
    step(1'b1, NS, 1'b0, 3'd2, 32'h20, 32'd0);
    chk("t3_c1_wen", 32'(sram_wen), 32'd0);
    chk("t3_c1_addr", 32'(sram_addr), 32'h008);
    step(1'b1, NS, 1'b0, 3'd2, 32'h30, 32'd0);
    chk("t3_c2_wen", 32'(sram_wen), 32'd0);
    step(1'b1, NS, 1'b0, 3'd2, 32'h10, 32'd0);
    chk("t3_c3_wen", 32'(sram_wen), 32'd0);
    idle();
    chk("t3_fwd", hrdata, 32'h0BADF00D);
    chk("t3_commit_wen", 32'(sram_wen), 32'hF);
    chk("t3_commit_addr", 32'(sram_addr), 32'h004);
    idle();
    chk("t3_commits", 32'(wr_count - wc0), 32'd1);

    // Upper half-word write
    step(1'b1, NS, 1'b1, 3'd1, 32'h42, 32'hBEEF0000);
    idle();
    chk("t4_wen", 32'(sram_wen), 32'hC);
    chk("t4_wdata_hi", 32'(sram_wdata[31:16]), 32'h0000BEEF);
    chk("t4_addr", 32'(sram_addr), 32'h010);

    // Out-of-range read
    step(1'b1, NS, 1'b0, 3'd2, 32'h3000, 32'd0);
    chk("t5_cs", 32'(sram_cs), 32'd0);
    idle();
`ifdef AHB_SRAM_RANGE_ERR_EN
    chk("t5_err1_ready", 32'(hreadyout), 32'd0);
    chk("t5_err1_resp", 32'(hresp), 32'd1);
    idle();
    chk("t5_err2_ready", 32'(hreadyout), 32'd1);
    chk("t5_err2_resp", 32'(hresp), 32'd1);
`else
    chk("t5_rdata", hrdata, 32'd0);
    chk("t5_resp", 32'(hresp), 32'd0);
    chk("t5_ready", 32'(hreadyout), 32'd1);
`endif
    idle();

    // Illegal size: two-cycle ERROR, address phase during the first cycle ignored
    step(1'b1, NS, 1'b1, 3'd3, 32'h100, 32'h12345678);
    step(1'b1, NS, 1'b0, 3'd2, 32'h100, 32'd0);
    chk("t5s_err1_ready", 32'(hreadyout), 32'd0);
    chk("t5s_err1_resp", 32'(hresp), 32'd1);
    chk("t5s_err1_cs", 32'(sram_cs), 32'd0);
    idle();
    chk("t5s_err2_ready", 32'(hreadyout), 32'd1);
    chk("t5s_err2_resp", 32'(hresp), 32'd1);
    chk("t5s_err2_cs", 32'(sram_cs), 32'd0);
    idle();
    chk("t5s_after_resp", 32'(hresp), 32'd0);
    chk("t5s_after_rdata", hrdata, 32'd0);

    // Reset right after a buffer fill: the pending write is lost
    step(1'b1, NS, 1'b1, 3'd2, 32'h240, 32'hCAFEF00D);
    step(1'b1, NS, 1'b0, 3'd2, 32'h300, 32'd0);
    reset_cycles(2);
    idle();
    step(1'b1, NS, 1'b0, 3'd2, 32'h240, 32'd0);
    idle();
    chk("t6_old_data", hrdata, 32'h55667788);

    // Mixed sizes and offsets, reads chasing writes to the same word
    for (int i = 0; i < 16; i++) begin
      logic [2:0]  sz;
      logic [31:0] off, a;
      sz  = 3'((i / 2) % 3);
      off = (sz == 3'd0) ? 32'(i % 4) : (sz == 3'd1) ? 32'((i % 2) * 2) : 32'd0;
      a   = 32'h400 + 32'(((i / 4) % 2) * 4) + off;
      step(1'b1, NS, (i % 2) == 0, sz, a, 32'h01020304 * 32'(i + 1));
    end
    repeat (3) idle();

    for (int w = 0; w < 3072; w++) chk("mem_image", sram_mem[w], ref_mem[w]);

    chk_on = 1'b0;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/ahb_sram_ctrl.md
Name: ahb_sram_ctrl

Overview:
- AHB-Lite slave that sits directly upstream of the 3K x 32 system SRAM macro (synchronous, one-cycle read latency, per-byte write enables).
- Converts CPU bus transfers into SRAM cycles with zero wait states.
- A single-entry write buffer resolves the port conflict between a data-phase write and a following address-phase read.
- Read data is forwarded from the write buffer when a read hits the pending write.

Parameters:
- AW, 12, word-address width driven to the macro (SRAMADDR width).
- DEPTH, 3072, number of implemented 32-bit words; word index >= DEPTH is out of range.

Ports:
- HCLK  input  1  system clock.
- HRESETn  input  1  asynchronous active-low reset.
- HSEL  input  1  slave select.
- HADDR  input  32  byte address; HADDR[AW+1:2] is the word index.
- HTRANS  input  2  transfer type; only NONSEQ/SEQ (HTRANS[1]=1) are active.
- HWRITE  input  1  1 = write.
- HSIZE  input  3  0 = byte, 1 = half, 2 = word.
- HWDATA  input  32  write data, valid in data phase.
- HREADY  input  1  bus-level ready.
- HREADYOUT  output  1  slave ready.
- HRDATA  output  32  read data.
- HRESP  output  1  0 = OKAY, 1 = ERROR.
- SRAMRDATA  input  32  macro read data, valid the cycle after the enabled read edge.
- SRAMWEN  output  4  per-byte write enable; 0000 = read.
- SRAMWDATA  output  32  macro write data.
- SRAMCS0  output  1  macro enable.
- SRAMADDR  output  AW  macro word address.

Behaviour:
- Clock and reset: single clock HCLK; reset HRESETn is asynchronous and active-low. While reset is low:
  - HREADYOUT=1, HRESP=0, HRDATA=0.
  - SRAMCS0=0, SRAMWEN=0.
  - Write buffer and data-phase registers are cleared. A pending buffered write is discarded.
- Accept: address phase is accepted when HSEL & HREADY & HTRANS[1].
- Byte lanes: little-endian. be = 0001<<HADDR[1:0] for a byte, 0011<<{HADDR[1],0} for a half, 1111 for a word. Misaligned low address bits are ignored.
- Macro port priority per cycle:
  - (1) An accepted read in its address phase drives SRAMCS0=1, SRAMWEN=0, SRAMADDR=word index, combinationally from HADDR.
  - (2) Otherwise, if the buffer is valid, commit it and clear it.
  - (3) Otherwise, a data-phase write goes straight to the macro: SRAMWEN=registered be, SRAMWDATA=HWDATA.
- Buffer fill: if a data-phase write coincides with case (1), the buffer captures {addr, be, HWDATA} at the clock edge.
- Invariant: a fill and a commit are never required in the same cycle, so a single entry suffices and HREADYOUT stays 1 for all legal transfers. The verifier asserts that no buffer fill ever occurs while the buffer is valid.
- Read data phase: HRDATA byte i = buffer byte i if (buffer valid & buffer addr == read addr & buffer be[i]); otherwise SRAMRDATA byte i. The buffer contents used are the current-cycle contents, including a buffer that commits in this same cycle.
- IDLE/BUSY or unselected: OKAY, zero wait, no macro access.
- HRDATA outside a read data phase is 0.
- Error response (HSIZE>2, or word index >= DEPTH with the feature enabled):
  - No macro access.
  - Two-cycle response: cycle 1 HREADYOUT=0, HRESP=1; cycle 2 HREADYOUT=1, HRESP=1.
  - An address phase presented during cycle 1 is ignored (HREADY=0).
- Reset mid-transfer: all state returns to reset values immediately; no partial macro write is issued after HRESETn falls.

Optional Feature:
- Macro: AHB_SRAM_RANGE_ERR_EN.
- Defined: an access with word index >= DEPTH returns the two-cycle ERROR response.
- Undefined: an out-of-range read returns 0 with OKAY, an out-of-range write is dropped (SRAMCS0 stays 0), zero wait. HSIZE>2 still errors in both builds.

Test Plan:
- Word write 0xDEADBEEF to 0x100, then idle, then read 0x100 -> SRAMWEN=1111, addr 0x40 in the write's data phase; HRDATA=0xDEADBEEF, HREADYOUT always 1.
- Byte write 0xAA to 0x203 immediately followed by a word read of 0x200 (memory holds 0x11223344) -> read issued first; HRDATA=0xAA223344 by forwarding; buffer commits on the next non-read cycle with SRAMWEN=1000.
- Write W1 to 0x10, then reads R(0x20), R(0x30), R(0x10) back-to-back -> buffer held through the read cycles; R(0x10) returns W1 data; one commit total; zero wait states throughout.
- Half write 0xBEEF to 0x42 -> SRAMWEN=1100, SRAMWDATA[31:16]=0xBEEF.
- Read of word 3072 (0x3000) with AHB_SRAM_RANGE_ERR_EN -> HREADYOUT 0 then 1, HRESP=1 on both cycles, SRAMCS0=0. Without the macro -> HRDATA=0, OKAY.
- Assert HRESETn low in the cycle after a buffer fill -> buffer cleared, no commit, outputs at reset values; a subsequent read of that address returns the old macro contents.
